// File: rtl/bus_arb_pkg.sv
// Purpose: shared state encoding, counter width default and grant-state helper for the bus mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_TURN   = 2'd3
  } arb_state_e;

  // Map a requester index to its grant state.
  function automatic arb_state_e grant_of(input logic idx);
    return idx ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Purpose: loadable saturating up-counter with synchronous clear (hold / turnaround timing).
// Latency: count updates on the clock edge after clr_i/load_i/inc_i.
// Backpressure: none; sticks at all-ones instead of wrapping.
// Ports: clk_i, rst_n_i (async active-low), clr_i (highest priority), load_i + load_val_i,
//        inc_i (count up), cnt_o (current count).
module arb_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_mux_arbiter.sv
// Purpose: two-requester round-robin arbiter driving a shared 2:1 mux (Enable/Sel) with grants back.
// Latency: Req -> Gnt one cycle; all outputs registered, decoded from the next state.
// Backpressure: owner preempted after MAX_HOLD cycles if the other side waits and Lock is low;
//               TURN_CYCLES dead cycles with MuxEnable low between owners.
// Ports: Clock, Reset_n (async active-low); Req_0/Req_1 requests; Lock_0/Lock_1 no-preempt;
//        Gnt_0/Gnt_1 grants; MuxEnable/MuxSel to the mux; Busy high outside IDLE.
module bus_mux_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Req_0,
  input  logic Req_1,
  input  logic Lock_0,
  input  logic Lock_1,
  output logic Gnt_0,
  output logic Gnt_1,
  output logic MuxEnable,
  output logic MuxSel,
  output logic Busy
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] TURN_LIM = CNT_W'(TURN_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt1_q, en_q, sel_q, busy_q;
  logic [CNT_W-1:0] hold_cnt, turn_cnt;
  logic             hold_inc, turn_inc;

  arb_sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk_i      (Clock),
    .rst_n_i    (Reset_n),
    .clr_i      (!hold_inc),
    .load_i     (1'b0),
    .load_val_i ({CNT_W{1'b0}}),
    .inc_i      (hold_inc),
    .cnt_o      (hold_cnt)
  );

  arb_sat_counter #(.W(CNT_W)) u_turn_cnt (
    .clk_i      (Clock),
    .rst_n_i    (Reset_n),
    .clr_i      (!turn_inc),
    .load_i     (1'b0),
    .load_val_i ({CNT_W{1'b0}}),
    .inc_i      (turn_inc),
    .cnt_o      (turn_cnt)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Req_0 && Req_1)  state_d = grant_of(!last_q);
        else if (Req_0)      state_d = ST_GRANT0;
        else if (Req_1)      state_d = ST_GRANT1;
      end
      ST_GRANT0: begin
        // Saturated count (>=) keeps preemption armed after a long locked hold.
        if (!Req_0 || (Req_1 && !Lock_0 && (hold_cnt >= HOLD_LIM))) begin
          last_d  = 1'b0;
          state_d = Req_1 ? ST_TURN : ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (!Req_1 || (Req_0 && !Lock_1 && (hold_cnt >= HOLD_LIM))) begin
          last_d  = 1'b1;
          state_d = Req_0 ? ST_TURN : ST_IDLE;
        end
      end
      ST_TURN: begin
        if (turn_cnt >= TURN_LIM) begin
          // Non-last owner first, then the last owner, requests sampled at exit.
          if (last_q ? Req_0 : Req_1)       state_d = grant_of(!last_q);
          else if (last_q ? Req_1 : Req_0)  state_d = grant_of(last_q);
          else                              state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters run only while staying in the same grant / turn state; any exit clears them.
  assign hold_inc = ((state_q == ST_GRANT0) || (state_q == ST_GRANT1)) && (state_d == state_q);
  assign turn_inc = (state_q == ST_TURN) && (state_d == ST_TURN);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt0_q  <= (state_d == ST_GRANT0);
      gnt1_q  <= (state_d == ST_GRANT1);
      en_q    <= (state_d == ST_GRANT0) || (state_d == ST_GRANT1);
      // During TURN the select parks on the owner that just left.
      sel_q   <= (state_d == ST_GRANT1) || ((state_d == ST_TURN) && last_d);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign Gnt_0     = gnt0_q;
  assign Gnt_1     = gnt1_q;
  assign MuxEnable = en_q;
  assign MuxSel    = sel_q;
  assign Busy      = busy_q;

  a_one_owner : assert property (@(posedge Clock) disable iff (!Reset_n) !(Gnt_0 && Gnt_1));
  a_en_grant  : assert property (@(posedge Clock) disable iff (!Reset_n) MuxEnable == (Gnt_0 | Gnt_1));
  a_sel_owner : assert property (@(posedge Clock) disable iff (!Reset_n) MuxEnable |-> (MuxSel == Gnt_1));

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Purpose: scoreboard bench for bus_mux_arbiter with a behavioural 2:1 mux in the loop.
// Latency: expected outputs are queued per driven cycle and checked 1 ns after the sampling edge.
// Backpressure: n/a.
module tb_bus_mux_arbiter;

  localparam int MAX_HOLD    = 8;
  localparam int TURN_CYCLES = 1;
  localparam int WAIT_BOUND  = MAX_HOLD + TURN_CYCLES + 1;

  typedef struct packed {
    logic       g0;
    logic       g1;
    logic       en;
    logic       sel;
    logic       busy;
    logic [7:0] mo;
  } exp_t;

  logic       Clock;
  logic       Reset_n;
  logic       Req_0, Req_1, Lock_0, Lock_1;
  logic       Gnt_0, Gnt_1, MuxEnable, MuxSel, Busy;
  logic [7:0] din0, din1, mux_out;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: who owns the bus, how long it has held it, turnaround progress.
  int m_owner;      // -1 = nobody
  int m_held;       // grant cycles so far including the current one
  int m_last;       // last requester that released the bus
  bit m_turning;
  int m_turn_done;

  int wait_c[2];
  bit lock_seen[2];

  bus_mux_arbiter #(
    .MAX_HOLD    (MAX_HOLD),
    .TURN_CYCLES (TURN_CYCLES),
    .CNT_W       (4)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Req_0     (Req_0),
    .Req_1     (Req_1),
    .Lock_0    (Lock_0),
    .Lock_1    (Lock_1),
    .Gnt_0     (Gnt_0),
    .Gnt_1     (Gnt_1),
    .MuxEnable (MuxEnable),
    .MuxSel    (MuxSel),
    .Busy      (Busy)
  );

  // Behavioural Multiplexer_2 with output forced low when disabled.
  assign mux_out = MuxEnable ? (MuxSel ? din1 : din0) : 8'h00;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_owner     = -1;
    m_held      = 0;
    m_last      = 1;
    m_turning   = 1'b0;
    m_turn_done = 0;
    for (int i = 0; i < 2; i++) begin
      wait_c[i]    = 0;
      lock_seen[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit r0, input bit r1, input bit l0, input bit l1, output exp_t e);
    bit r[2];
    bit l[2];
    int x;
    r[0] = r0; r[1] = r1; l[0] = l0; l[1] = l1;
    if (m_turning) begin
      m_turn_done++;
      if (m_turn_done >= TURN_CYCLES) begin
        m_turning = 1'b0;
        if (r[1 - m_last])   begin m_owner = 1 - m_last; m_held = 1; end
        else if (r[m_last])  begin m_owner = m_last;     m_held = 1; end
        else                 m_owner = -1;
      end
    end else if (m_owner >= 0) begin
      x = m_owner;
      if (!r[x] || (m_held >= MAX_HOLD && r[1 - x] && !l[x])) begin
        m_last      = x;
        m_owner     = -1;
        m_turning   = r[1 - x];
        m_turn_done = 0;
      end else begin
        m_held++;
      end
    end else begin
      if (r[0] && r[1])  m_owner = 1 - m_last;
      else if (r[0])     m_owner = 0;
      else if (r[1])     m_owner = 1;
      m_held = 1;
    end
    e.g0   = (m_owner == 0);
    e.g1   = (m_owner == 1);
    e.en   = (m_owner >= 0);
    e.sel  = m_turning ? (m_last == 1) : (m_owner == 1);
    e.busy = m_turning || (m_owner >= 0);
    e.mo   = e.g0 ? din0 : (e.g1 ? din1 : 8'h00);
  endtask

  // Drive one cycle of stimulus on the falling edge and queue its expected response.
  task automatic drive(input bit r0, input bit r1, input bit l0, input bit l1);
    exp_t e;
    @(negedge Clock);
    Req_0  = r0;
    Req_1  = r1;
    Lock_0 = l0;
    Lock_1 = l1;
    din0   = 8'($urandom);
    din1   = 8'($urandom);
    model_step(r0, r1, l0, l1, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    Req_0 = 1'b0; Req_1 = 1'b0; Lock_0 = 1'b0; Lock_1 = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge Clock);
    chk("reset_outputs", int'({Gnt_0, Gnt_1, MuxEnable, MuxSel, Busy}), 0);
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  // Monitor: compare every driven cycle against the scoreboard and track waiting time.
  always @(posedge Clock) begin
    #1;
    if (Reset_n && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if ({Gnt_0, Gnt_1, MuxEnable, MuxSel, Busy, mux_out} !== mon_e) begin
        bad++;
        $display("FAIL cycle_outputs got g0=%b g1=%b en=%b sel=%b busy=%b mux=%h want g0=%b g1=%b en=%b sel=%b busy=%b mux=%h t=%0t",
                 Gnt_0, Gnt_1, MuxEnable, MuxSel, Busy, mux_out,
                 mon_e.g0, mon_e.g1, mon_e.en, mon_e.sel, mon_e.busy, mon_e.mo, $time);
      end
      for (int i = 0; i < 2; i++) begin
        if (!(i == 0 ? Req_0 : Req_1) || (i == 0 ? Gnt_0 : Gnt_1)) begin
          wait_c[i]    = 0;
          lock_seen[i] = 1'b0;
        end else begin
          wait_c[i]++;
          if (i == 0 ? Lock_1 : Lock_0) lock_seen[i] = 1'b1;
          if (!lock_seen[i]) begin
            total++;
            if (wait_c[i] > WAIT_BOUND) begin
              bad++;
              $display("FAIL max_wait req%0d waited=%0d bound=%0d t=%0t", i, wait_c[i], WAIT_BOUND, $time);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    bit found;
    bit r0, r1, l0, l1;
    Reset_n = 1'b0;
    Req_0 = 1'b0; Req_1 = 1'b0; Lock_0 = 1'b0; Lock_1 = 1'b0;
    din0 = 8'h00; din1 = 8'h00;
    model_reset();
    #12;

    // Single requester grant and release.
    do_reset();
    drive(1, 0, 0, 0);
    @(posedge Clock); #2;
    chk("single_grant", int'({Gnt_0, MuxEnable, MuxSel}), 3'b110);
    drive(0, 0, 0, 0);
    @(posedge Clock); #2;
    chk("release_idle", int'({Gnt_0, Gnt_1, MuxEnable, MuxSel, Busy}), 0);

    // Both requesting from reset: 8 on, 1 dead, 8 on, 1 dead, repeating.
    do_reset();
    for (int k = 0; k < 38; k++) begin
      drive(1, 1, 0, 0);
      @(posedge Clock); #2;
      chk("alternate_g0", int'(Gnt_0), int'((k % 18) < 8));
      chk("alternate_g1", int'(Gnt_1), int'(((k % 18) >= 9) && ((k % 18) < 17)));
    end

    // Locked owner 1 holds off requester 0, then yields once unlocked.
    do_reset();
    drive(0, 1, 0, 0);
    held = 0;
    for (int k = 0; k < 30; k++) begin
      drive(1, 1, 0, 1);
      @(posedge Clock); #2;
      if (Gnt_1) held++;
    end
    chk("lock_hold_cycles", held, 30);
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 0, 0);
      @(posedge Clock); #2;
      if (!Gnt_1) found = 1'b1;
    end
    chk("unlock_preempt", int'(found), 1);

    // Req_1 drops during TURN: the last owner 0 is granted again.
    do_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    @(posedge Clock); #2;
    chk("turn_regrant_g0", int'({Gnt_0, Gnt_1}), 2'b10);

    // Asynchronous reset in the middle of a GRANT1 window.
    do_reset();
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    @(posedge Clock); #3;
    chk("pre_reset_g1", int'(Gnt_1), 1);
    Reset_n = 1'b0;
    #1;
    chk("async_reset_clear", int'({Gnt_1, MuxEnable, MuxSel, Busy}), 0);
    exp_q.delete();
    model_reset();
    @(negedge Clock);
    Req_0 = 1'b0; Req_1 = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    drive(1, 1, 0, 0);
    @(posedge Clock); #2;
    chk("pointer_after_reset", int'({Gnt_0, Gnt_1}), 2'b10);

    // Random traffic: unlocked phase, then with occasional locks.
    do_reset();
    r0 = 1'b0; r1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(7) == 0) r0 = ~r0;
      if ($urandom_range(7) == 0) r1 = ~r1;
      if (k >= 3000) begin
        if ($urandom_range(15) == 0) l0 = ~l0;
        if ($urandom_range(15) == 0) l1 = ~l1;
      end
      drive(r0, r1, l0, l1);
    end
    drive(0, 0, 0, 0);
    repeat (3) @(posedge Clock);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
